// File: rtl/addsub_seq_pkg.sv
// Shared types and carry mapping for the multi-byte add/subtract sequencer.
package addsub_seq_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // 6502 C flag to addsub carry_in: binary subtract takes a borrow, all other modes a carry.
  function automatic logic carry_map(input logic sub, input logic dec, input logic c);
    return (sub && !dec) ? ~c : c;
  endfunction

endpackage

// File: rtl/addsub_seq_addsub.sv
// Combinational 8-bit binary/BCD add/subtract unit; carry_out is 6502-style (sub: 1 = no borrow).
module addsub_seq_addsub
  import addsub_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  output logic [BYTE_W-1:0] y,
  input  logic              add_sub,
  input  logic              decen,
  input  logic              carry_in,
  output logic              carry_out
);

  logic [BYTE_W:0] bin;
  logic [4:0]      lo;
  logic [4:0]      hi;
  logic            lc;
  logic            hc;

  always_comb begin
    bin       = '0;
    lo        = '0;
    hi        = '0;
    lc        = 1'b0;
    hc        = 1'b0;
    y         = '0;
    carry_out = 1'b0;
    if (!add_sub) begin
      if (decen) begin
        lo = 5'(a[3:0]) + 5'(b[3:0]) + 5'(carry_in);
        lc = (lo > 5'd9);
        if (lc) lo = lo + 5'd6;
        hi = 5'(a[7:4]) + 5'(b[7:4]) + 5'(lc);
        hc = (hi > 5'd9);
        if (hc) hi = hi + 5'd6;
        y         = {hi[3:0], lo[3:0]};
        carry_out = hc;
      end else begin
        bin       = 9'(a) + 9'(b) + 9'(carry_in);
        y         = bin[7:0];
        carry_out = bin[8];
      end
    end else begin
      // Decimal subtract: carry_in is 6502-style, so the borrow is its inverse.
      if (decen) begin
        lo = 5'(a[3:0]) - 5'(b[3:0]) - 5'(~carry_in);
        lc = lo[4];
        if (lc) lo = lo - 5'd6;
        hi = 5'(a[7:4]) - 5'(b[7:4]) - 5'(lc);
        hc = hi[4];
        if (hc) hi = hi - 5'd6;
        y         = {hi[3:0], lo[3:0]};
        carry_out = ~hc;
      end else begin
        bin       = 9'(a) - 9'(b) - 9'(carry_in);
        y         = bin[7:0];
        carry_out = ~bin[8];
      end
    end
  end

endmodule

// File: rtl/addsub_seq.sv
// Multi-byte ADC/SBC sequencer: one byte per cycle through addsub, LSB first, 6502 N/V/Z/C flags.
// Define ADDSUB_SEQ_DEC_EN to enable BCD mode via req_dec; otherwise all operations are binary.
module addsub_seq
  import addsub_seq_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [BYTE_W*NBYTES-1:0]     req_a,
  input  logic [BYTE_W*NBYTES-1:0]     req_b,
  input  logic [$clog2(NBYTES)-1:0]    req_len,
  input  logic                         req_sub,
  input  logic                         req_dec,
  input  logic                         req_carry,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [BYTE_W*NBYTES-1:0]     res_y,
  output logic                         res_c,
  output logic                         res_v,
  output logic                         res_n,
  output logic                         res_z
);

  localparam int unsigned W     = BYTE_W * NBYTES;
  localparam int unsigned LEN_W = $clog2(NBYTES);

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d, y_q, y_d;
  logic [LEN_W-1:0]   len_q, len_d, idx_q, idx_d;
  logic               sub_q, sub_d, dec_q, dec_d, c_q, c_d;
  logic               zacc_q, zacc_d, n_q, n_d, v_q, v_d;
  logic               ready_q, ready_d, valid_q, valid_d;

  logic               dec_in;
  logic [BYTE_W-1:0]  a_byte, b_byte, add_y;
  logic               add_cin, add_co;

`ifdef ADDSUB_SEQ_DEC_EN
  assign dec_in = req_dec;
`else
  logic unused_dec;
  assign unused_dec = req_dec;
  assign dec_in     = 1'b0;
`endif

  assign a_byte  = a_q[BYTE_W*int'(idx_q) +: BYTE_W];
  assign b_byte  = b_q[BYTE_W*int'(idx_q) +: BYTE_W];
  assign add_cin = carry_map(sub_q, dec_q, c_q);

  addsub_seq_addsub addsub (
    .a         (a_byte),
    .b         (b_byte),
    .y         (add_y),
    .add_sub   (sub_q),
    .decen     (dec_q),
    .carry_in  (add_cin),
    .carry_out (add_co)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    len_d   = len_q;
    idx_d   = idx_q;
    sub_d   = sub_q;
    dec_d   = dec_q;
    c_d     = c_q;
    zacc_d  = zacc_q;
    n_d     = n_q;
    v_d     = v_q;
    case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          a_d     = req_a;
          b_d     = req_b;
          len_d   = req_len;
          sub_d   = req_sub;
          dec_d   = dec_in;
          c_d     = req_carry;
          idx_d   = '0;
          y_d     = '0;
          zacc_d  = 1'b1;
          n_d     = 1'b0;
          v_d     = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        y_d[BYTE_W*int'(idx_q) +: BYTE_W] = add_y;
        zacc_d = zacc_q & (add_y == '0);
        c_d    = add_co;
        // Final byte: capture sign and overflow; idx stops here so it never wraps.
        if (idx_q == len_q) begin
          n_d     = add_y[BYTE_W-1];
          v_d     = (a_byte[BYTE_W-1] == (b_byte[BYTE_W-1] ^ sub_q)) &&
                    (add_y[BYTE_W-1] != a_byte[BYTE_W-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + LEN_W'(1);
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      sub_q   <= 1'b0;
      dec_q   <= 1'b0;
      c_q     <= 1'b0;
      zacc_q  <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      sub_q   <= sub_d;
      dec_q   <= dec_d;
      c_q     <= c_d;
      zacc_q  <= zacc_d;
      n_q     <= n_d;
      v_q     <= v_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign req_ready = ready_q;
  assign res_valid = valid_q;
  assign res_y     = y_q;
  assign res_c     = c_q;
  assign res_v     = v_q;
  assign res_n     = n_q;
  assign res_z     = zacc_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq: directed table, handshake/reset sequences, randomized vs. integer model.
module tb_addsub_seq;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;
  localparam int unsigned LW = $clog2(NB);

  logic          clk, rst;
  logic          req_valid, req_ready, req_sub, req_dec, req_carry;
  logic          res_valid, res_ready, res_c, res_v, res_n, res_z;
  logic [W-1:0]  req_a, req_b, res_y;
  logic [LW-1:0] req_len;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [LW-1:0] len;
    logic          sub;
    logic          dec;
    logic          c;
    logic [W-1:0]  y;
    logic          ec;
    logic          ev;
    logic          en;
    logic          ez;
  } vec_t;

  vec_t tbl[$];

  addsub_seq #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_len   (req_len),
    .req_sub   (req_sub),
    .req_dec   (req_dec),
    .req_carry (req_carry),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_y     (res_y),
    .res_c     (res_c),
    .res_v     (res_v),
    .res_n     (res_n),
    .res_z     (res_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input longint unsigned act,
                                input longint unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic longint unsigned bcd2int(input logic [W-1:0] x, input int nb);
    longint unsigned r;
    r = 0;
    for (int i = 2 * nb - 1; i >= 0; i--) r = r * 10 + 64'(x[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint unsigned val, input int nb);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 2 * nb; i++) begin
      r[4*i +: 4] = 4'(val % 10);
      val = val / 10;
    end
    return r;
  endfunction

  // Reference: whole-operand integer arithmetic in binary or decimal radix.
  function automatic vec_t model(input vec_t v);
    int              nb;
    logic            dec_on;
    longint unsigned m, av, bv, r, cin;
    logic [7:0]      at, bt, yt;
    nb  = int'(v.len) + 1;
    cin = v.c ? 64'd1 : 64'd0;
`ifdef ADDSUB_SEQ_DEC_EN
    dec_on = v.dec;
`else
    dec_on = 1'b0;
`endif
    if (dec_on) begin
      m = 1;
      for (int i = 0; i < 2 * nb; i++) m = m * 10;
      av = bcd2int(v.a, nb);
      bv = bcd2int(v.b, nb);
    end else begin
      m  = 64'd1 << (8 * nb);
      av = 64'(v.a) & (m - 1);
      bv = 64'(v.b) & (m - 1);
    end
    if (!v.sub) begin
      r    = av + bv + cin;
      v.ec = (r >= m);
      if (v.ec) r = r - m;
    end else begin
      v.ec = (av >= bv + (1 - cin));
      r    = v.ec ? (av - bv - (1 - cin)) : (av + m - bv - (1 - cin));
    end
    v.y  = dec_on ? int2bcd(r, nb) : W'(r);
    v.ez = (r == 0);
    at   = v.a[8*(nb-1) +: 8];
    bt   = v.b[8*(nb-1) +: 8];
    yt   = v.y[8*(nb-1) +: 8];
    if (v.sub) bt = ~bt;
    v.en = yt[7];
    v.ev = (at[7] == bt[7]) && (yt[7] != at[7]);
    return v;
  endfunction

  function automatic void add_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [LW-1:0] len, input logic sub, input logic dec,
                                  input logic c, input logic [W-1:0] y, input logic ec,
                                  input logic ev, input logic en, input logic ez);
    vec_t v;
    v.a = a; v.b = b; v.len = len; v.sub = sub; v.dec = dec; v.c = c;
    v.y = y; v.ec = ec; v.ev = ev; v.en = en; v.ez = ez;
    tbl.push_back(v);
  endfunction

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, " req_ready"}, 64'(req_ready), 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input int hold, input string tag);
    int lat;
    wait_ready(tag);
    req_a = v.a; req_b = v.b; req_len = v.len;
    req_sub = v.sub; req_dec = v.dec; req_carry = v.c;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = W'($urandom); req_b = W'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (res_valid !== 1'b1 && lat < 20);
    check({tag, " latency"}, 64'(lat), 64'(int'(v.len) + 1));
    check({tag, " y"}, 64'(res_y), 64'(v.y));
    check({tag, " c"}, 64'(res_c), 64'(v.ec));
    check({tag, " v"}, 64'(res_v), 64'(v.ev));
    check({tag, " n"}, 64'(res_n), 64'(v.en));
    check({tag, " z"}, 64'(res_z), 64'(v.ez));
    repeat (hold) begin @(posedge clk); #1; end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({tag, " valid drop"}, 64'(res_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   k;
    n_chk = 0; n_fail = 0;
    rst = 1'b1; req_valid = 1'b0; res_ready = 1'b0;
    req_a = '0; req_b = '0; req_len = '0; req_sub = 1'b0; req_dec = 1'b0; req_carry = 1'b0;

    // Reset state
    #12;
    check("rst req_ready", 64'(req_ready), 64'd0);
    check("rst res_valid", 64'(res_valid), 64'd0);
    check("rst res_y", 64'(res_y), 64'd0);
    check("rst flags", 64'({res_c, res_v, res_n, res_z}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post-rst req_ready", 64'(req_ready), 64'd1);

    // Directed vectors: a, b, len, sub, dec, c -> y, C, V, N, Z
    add_vec(32'h0000_12FF, 32'h0000_0001, 2'd1, 1'b0, 1'b0, 1'b0, 32'h0000_1300, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(32'h0000_0000, 32'h0000_0001, 2'd3, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    add_vec(32'h0000_007F, 32'h0000_0001, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0080, 1'b0, 1'b1, 1'b1, 1'b0);
    add_vec(32'h0000_0080, 32'h0000_0001, 2'd0, 1'b1, 1'b0, 1'b1, 32'h0000_007F, 1'b1, 1'b1, 1'b0, 1'b0);
    add_vec(32'hAB00_0000, 32'hCD00_0000, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef ADDSUB_SEQ_DEC_EN
    add_vec(32'h0000_9999, 32'h0000_0001, 2'd1, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    add_vec(32'h0000_0999, 32'h0000_0001, 2'd1, 1'b0, 1'b1, 1'b0, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(32'h0000_1000, 32'h0000_0001, 2'd1, 1'b1, 1'b1, 1'b1, 32'h0000_0999, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(32'h0000_0000, 32'h0000_0001, 2'd1, 1'b1, 1'b1, 1'b1, 32'h0000_9999, 1'b0, 1'b0, 1'b1, 1'b0);
`else
    add_vec(32'h0000_9999, 32'h0000_0001, 2'd1, 1'b0, 1'b1, 1'b0, 32'h0000_999A, 1'b0, 1'b0, 1'b1, 1'b0);
    add_vec(32'h0000_1000, 32'h0000_0001, 2'd1, 1'b1, 1'b1, 1'b1, 32'h0000_0FFF, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], 0, $sformatf("vec%0d", i));

    // Result held while res_ready stays low; new requests ignored
    v.a = 32'h0012_3456; v.b = 32'h0065_4321; v.len = 2'd2;
    v.sub = 1'b0; v.dec = 1'b0; v.c = 1'b1;
    v = model(v);
    wait_ready("hold");
    req_a = v.a; req_b = v.b; req_len = v.len; req_sub = v.sub; req_dec = v.dec; req_carry = v.c;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    while (res_valid !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    check("hold y", 64'(res_y), 64'h0077_7778);
    req_valid = 1'b1; req_a = 32'hDEAD_BEEF; req_b = 32'h1234_5678; req_len = 2'd3;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("hold res_valid", 64'(res_valid), 64'd1);
      check("hold req_ready", 64'(req_ready), 64'd0);
      check("hold res_y", 64'(res_y), 64'(v.y));
      check("hold flags", 64'({res_c, res_v, res_n, res_z}), 64'({v.ec, v.ev, v.en, v.ez}));
    end
    req_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("hold release valid", 64'(res_valid), 64'd0);
    check("hold release ready", 64'(req_ready), 64'd1);
    repeat (6) begin @(posedge clk); #1; end
    check("hold no stray result", 64'(res_valid), 64'd0);

    // Asynchronous reset in the middle of RUN
    wait_ready("midrst");
    req_a = 32'h1111_1111; req_b = 32'h2222_2222; req_len = 2'd3;
    req_sub = 1'b0; req_dec = 1'b0; req_carry = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("midrst partial y", 64'(res_y), 64'h0000_0033);
    #2 rst = 1'b1;
    #1;
    check("midrst res_valid", 64'(res_valid), 64'd0);
    check("midrst res_y", 64'(res_y), 64'd0);
    check("midrst req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst ready after", 64'(req_ready), 64'd1);
    repeat (5) begin @(posedge clk); #1; end
    check("midrst no result", 64'(res_valid), 64'd0);
    run_vec(tbl[0], 1, "after_rst");

    // Randomized operations against the integer model
    for (int i = 0; i < 80; i++) begin
      v.len = LW'($urandom_range(0, NB - 1));
      v.sub = 1'($urandom);
      v.dec = 1'($urandom);
      v.c   = 1'($urandom);
      v.a   = W'($urandom);
      v.b   = W'($urandom);
      if (v.dec) begin
        for (int d = 0; d < 2 * NB; d++) begin
          v.a[4*d +: 4] = 4'($urandom_range(0, 9));
          v.b[4*d +: 4] = 4'($urandom_range(0, 9));
        end
      end
      v = model(v);
      run_vec(v, int'($urandom_range(0, 2)), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_seq.md
# addsub_seq

Multi-byte arithmetic sequencer that drives the shared 8-bit `addsub` unit one byte per cycle. It performs binary or BCD add/subtract on operands of up to NBYTES bytes, least-significant byte first, and chains the carry between bytes. It returns a packed result with 6502-style N/V/Z/C flags over a valid/ready handshake. It sits between the microcode/execute stage and the `addsub` datapath for wide ADC/SBC-style operations.

## Interface
- NBYTES, 4, maximum operand length in bytes (2..8)
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_a  in  8*NBYTES  operand A
- req_b  in  8*NBYTES  operand B
- req_len  in  $clog2(NBYTES)  byte count minus one
- req_sub  in  1  0 = add, 1 = subtract
- req_dec  in  1  decimal (BCD) mode
- req_carry  in  1  carry in, 6502 convention (sub: 1 = no borrow)
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_y  out  8*NBYTES  result; bytes above req_len are zero
- res_c, res_v, res_n, res_z  out  1 each  flags

One clock (`clk`); reset `rst` is asynchronous and active-high.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: req_ready=1. When req_valid is high, latch the operands, len, sub, dec and carry, set idx=0, clear the result, set zacc=1, and go to RUN.
- RUN: present byte idx of A/B to `addsub`. Drive add_sub=sub and decen=dec.
- carry_in mapping: add gives C; binary sub gives ~C; decimal sub gives C. carry_out is always 6502-style and is stored directly as the new C.
- On each RUN edge: store y into result byte idx, set zacc &= (y==0), and increment idx.
- When idx==len on that edge, go to DONE.
- DONE: res_valid=1 and the outputs are held stable. On res_ready, go to IDLE.
- Flags:
  - N = bit 7 of byte len.
  - Z = zacc.
  - C = final carry.
  - V = (a7 == b'7) && (y7 != a7) on byte len, where b' = b for add and ~b for sub. V uses this binary formula in decimal mode too.
- req_* inputs are ignored outside IDLE. There is no abort.

## Timing
- Reset values: req_ready=0 while rst is asserted and 1 after release. res_valid=0, res_y=0, all flags 0. State is IDLE.
- Latency: res_valid rises len+1 edges after the accepting edge.
- Minimum issue interval is len+3 cycles: RUN bytes, one DONE cycle with immediate res_ready, one IDLE cycle.
- res_ready held low keeps DONE indefinitely; outputs do not change.
- rst mid-RUN or mid-DONE: go to IDLE immediately, discard the pending result, clear outputs.
- len=0 is a single-byte operation. len=NBYTES-1 uses the full width. idx never wraps.

## Configuration
- ADDSUB_SEQ_DEC_EN defined: req_dec drives decen and BCD operations are supported.
- ADDSUB_SEQ_DEC_EN undefined: decen is tied 0, req_dec is ignored, and all operations are binary. The carry_in mapping uses the binary rule.

## Structure
- Shared package: the state enum (IDLE/RUN/DONE) and the carry-mapping function. The function takes sub and dec and returns carry_in from C.
- One sub-module: an `addsub` instance (ports a, b, y, add_sub, decen, carry_in, carry_out). It is combinational and its output is registered in this block.
- Operand byte selection is an indexed part-select. No shift registers are required.

## Test plan
- Binary add: len=1, A=0x12FF, B=0x0001, C=0 -> y=0x00001300, C=0, Z=0, N=0, V=0. res_valid exactly 2 edges after accept.
- Binary sub: len=3, A=0, B=1, C=1 -> y=0xFFFFFFFF, C=0, N=1, Z=0.
- Decimal add: len=1, A=0x9999, B=0x0001, C=0 -> y=0x0000, C=1, Z=1. Second case: A=0x0999, B=0x0001 -> 0x1000, C=0.
- Decimal sub: len=1, A=0x1000, B=0x0001, C=1 -> y=0x0999, C=1. Second case: A=0x0000, B=0x0001 -> 0x9999, C=0.
- Overflow: len=0, add 0x7F+0x01, C=0 -> y=0x00000080, V=1, N=1. Also sub 0x80-0x01 with C=1 -> 0x7F, V=1.
- Handshake and reset:
  - Hold res_ready=0 for 10 cycles: outputs stable, req_ready=0, a new req_valid is ignored.
  - Assert rst during RUN: res_valid=0 and req_ready=1 after release.
  - A following request completes correctly.
